// File: rtl/py_rxword_pack_pkg.sv
// Shared constants and state type for the payload bit-to-word packer.
package py_rxword_pack_pkg;

  localparam int unsigned FEC_BLK   = 15;
  localparam int unsigned FEC_DAT   = 10;
  localparam int unsigned CRC_BITS  = 16;
  localparam int unsigned FEC_CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } dec_state_e;

endpackage

// File: rtl/py_rxword_pack_fec32_gate.sv
// FEC 2/3 block position counter; marks which symbol strobes carry data bits.
module py_fec32_gate
  import py_rxword_pack_pkg::*;
(
  input  logic clk_6M,
  input  logic rstz,
  input  logic run,
  input  logic clr,
  input  logic py_datvalid_p,
  input  logic fec32encode,
  output logic daten
);

  logic [FEC_CNT_W-1:0] blk_cnt;

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      blk_cnt <= '0;
    end else if (clr || !run) begin
      blk_cnt <= '0;
    end else if (py_datvalid_p) begin
      blk_cnt <= (blk_cnt == FEC_CNT_W'(FEC_BLK - 1)) ? '0 : blk_cnt + FEC_CNT_W'(1);
    end
  end

  // Last five positions of each 15-bit block are parity.
  assign daten = run & (~fec32encode | (blk_cnt < FEC_CNT_W'(FEC_DAT)));

endmodule

// File: rtl/py_rxword_pack.sv
// Packs decoded payload bits (LSB first) into SRAM words with address tracking and overflow guard.
module py_rxword_pack
  import py_rxword_pack_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ADR_W  = 8,
  parameter int unsigned LEN_W  = 13
) (
  input  logic              clk_6M,
  input  logic              rstz,
  input  logic              py_datvalid_p,
  input  logic              dec_st_p,
  input  logic              abort_p,
  input  logic              fec32encode,
  input  logic              crcencode,
  input  logic [LEN_W-1:0]  pylenbit,
  input  logic              rxbit,
  output logic              daten,
  output logic              dec_period,
  output logic [LEN_W-1:0]  bitcnt,
  output logic              dec_endp,
  output logic              wr_p,
  output logic [ADR_W-1:0]  wr_adr,
  output logic [WORD_W-1:0] wr_dat,
  output logic              ovf
);

  localparam int unsigned LG    = $clog2(WORD_W);
  localparam int unsigned TOT_W = LEN_W + 1;
  localparam int unsigned K_W   = LG + 1;
  localparam int unsigned WC_W  = ADR_W + 1;

  dec_state_e        state_q, state_d;
  logic [TOT_W-1:0]  total_c, total_q, bitcnt_q;
  logic [WORD_W-1:0] shreg, sh_next, part_word;
  logic [WC_W-1:0]   words_q;
  logic [K_W-1:0]    fill_c;
  logic              run, clr, accept, last_c, word_done, issue;

  assign total_c    = TOT_W'(pylenbit) + (crcencode ? TOT_W'(CRC_BITS) : TOT_W'(0));
  assign run        = (state_q == RUN);
  assign clr        = dec_st_p & (run | (total_c != '0));
  assign accept     = run & daten & py_datvalid_p & ~abort_p & ~dec_st_p;
  assign last_c     = accept & (bitcnt_q == total_q - TOT_W'(1));
  assign word_done  = accept & (bitcnt_q[LG-1:0] == LG'(WORD_W - 1));
  assign issue      = word_done | last_c;
  assign sh_next    = {rxbit, shreg[WORD_W-1:1]};
  // A full word shifts by zero, so one expression covers full and partial words.
  assign fill_c     = K_W'(bitcnt_q[LG-1:0]) + K_W'(1);
  assign part_word  = sh_next >> (K_W'(WORD_W) - fill_c);

  assign dec_period = run;
  assign dec_endp   = last_c;
  assign bitcnt     = bitcnt_q[LEN_W-1:0];

  py_fec32_gate u_fec32_gate (
    .clk_6M        (clk_6M),
    .rstz          (rstz),
    .run           (run),
    .clr           (clr),
    .py_datvalid_p (py_datvalid_p),
    .fec32encode   (fec32encode),
    .daten         (daten)
  );

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Restart outranks abort and end-of-payload.
  always_comb begin
    state_d = state_q;
    if (dec_st_p) begin
      state_d = (total_c != '0) ? RUN : IDLE;
    end else if (run && (abort_p || last_c)) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      total_q  <= '0;
      bitcnt_q <= '0;
      shreg    <= '0;
      words_q  <= '0;
      wr_p     <= 1'b0;
      wr_adr   <= '0;
      wr_dat   <= '0;
      ovf      <= 1'b0;
    end else begin
      wr_p <= 1'b0;
      if (clr) begin
        total_q  <= total_c;
        bitcnt_q <= '0;
        shreg    <= '0;
        words_q  <= '0;
        wr_adr   <= '0;
        ovf      <= 1'b0;
      end else begin
        if (run && abort_p) begin
          shreg <= '0;
        end else if (accept) begin
          shreg    <= sh_next;
          bitcnt_q <= bitcnt_q + TOT_W'(1);
        end
        // Once the address space is used up, every later word only flags overflow.
        if (issue) begin
          if (ovf || words_q[ADR_W]) begin
            ovf <= 1'b1;
          end else begin
            wr_p    <= 1'b1;
            wr_dat  <= part_word;
            words_q <= words_q + WC_W'(1);
          end
        end
        if (wr_p && (wr_adr != '1)) begin
          wr_adr <= wr_adr + ADR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_py_rxword_pack.sv
// Randomized directed bench: two packer configurations against a bit-list reference model.
module tb_py_rxword_pack;

  localparam int unsigned LEN_W = 13;

  logic             clk_6M, rstz, py_datvalid_p, dec_st_p, abort_p;
  logic             fec32encode, crcencode, rxbit;
  logic [LEN_W-1:0] pylenbit;

  logic             daten_a, dec_period_a, dec_endp_a, wr_p_a, ovf_a;
  logic [LEN_W-1:0] bitcnt_a;
  logic [7:0]       wr_adr_a;
  logic [31:0]      wr_dat_a;
  logic             daten_b, dec_period_b, dec_endp_b, wr_p_b, ovf_b;
  logic [LEN_W-1:0] bitcnt_b;
  logic [1:0]       wr_adr_b;
  logic [7:0]       wr_dat_b;

  py_rxword_pack #(.WORD_W(32), .ADR_W(8), .LEN_W(LEN_W)) u_big (
    .clk_6M(clk_6M), .rstz(rstz), .py_datvalid_p(py_datvalid_p), .dec_st_p(dec_st_p),
    .abort_p(abort_p), .fec32encode(fec32encode), .crcencode(crcencode),
    .pylenbit(pylenbit), .rxbit(rxbit), .daten(daten_a), .dec_period(dec_period_a),
    .bitcnt(bitcnt_a), .dec_endp(dec_endp_a), .wr_p(wr_p_a), .wr_adr(wr_adr_a),
    .wr_dat(wr_dat_a), .ovf(ovf_a));

  py_rxword_pack #(.WORD_W(8), .ADR_W(2), .LEN_W(LEN_W)) u_small (
    .clk_6M(clk_6M), .rstz(rstz), .py_datvalid_p(py_datvalid_p), .dec_st_p(dec_st_p),
    .abort_p(abort_p), .fec32encode(fec32encode), .crcencode(crcencode),
    .pylenbit(pylenbit), .rxbit(rxbit), .daten(daten_b), .dec_period(dec_period_b),
    .bitcnt(bitcnt_b), .dec_endp(dec_endp_b), .wr_p(wr_p_b), .wr_adr(wr_adr_b),
    .wr_dat(wr_dat_b), .ovf(ovf_b));

  initial clk_6M = 1'b0;
  always #5 clk_6M = ~clk_6M;

  typedef struct {
    int unsigned adr;
    logic [63:0] dat;
    int unsigned cyc;
  } wr_t;

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  wr_t         exp_a[$], got_a[$], exp_b[$], got_b[$];
  logic [63:0] first_a;

  // Reference model state: one payload as a growing list of accepted bits.
  bit          mrun, mfec;
  int          mpos, macc, mtot;
  int          m_words[2];
  bit          m_ovf[2];
  logic [63:0] m_word[2];
  int          ww[2] = '{32, 8};
  int          aw[2] = '{8, 2};

  always @(posedge clk_6M) cyc <= cyc + 1;

  always @(negedge clk_6M) begin
    if (wr_p_a) got_a.push_back('{adr: 32'(wr_adr_a), dat: 64'(wr_dat_a), cyc: cyc});
    if (wr_p_b) got_b.push_back('{adr: 32'(wr_adr_b), dat: 64'(wr_dat_b), cyc: cyc});
  end

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    macc = 0; mpos = 0;
    m_words = '{0, 0};
    m_ovf = '{1'b0, 1'b0};
  endtask

  task automatic model_bit(input logic b, input int unsigned c);
    wr_t w;
    int  bp;
    for (int d = 0; d < 2; d++) begin
      bp = macc % ww[d];
      if (bp == 0) m_word[d] = '0;
      m_word[d][bp] = b;
      if (bp == ww[d] - 1 || macc == mtot - 1) begin
        if (m_words[d] < (1 << aw[d])) begin
          w.adr = m_words[d]; w.dat = m_word[d]; w.cyc = c + 1;
          if (d == 0) exp_a.push_back(w); else exp_b.push_back(w);
          m_words[d]++;
        end else begin
          m_ovf[d] = 1'b1;
        end
      end
    end
    macc++;
    if (macc == mtot) mrun = 1'b0;
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check({tag, "_nwr_a"}, 64'(got_a.size()), 64'(exp_a.size()));
    check({tag, "_nwr_b"}, 64'(got_b.size()), 64'(exp_b.size()));
    first_a = (got_a.size() > 0) ? got_a[0].dat : 'x;
    n = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_adr_a"}, 64'(got_a[i].adr), 64'(exp_a[i].adr));
      check({tag, "_dat_a"}, got_a[i].dat, exp_a[i].dat);
      check({tag, "_lat_a"}, 64'(got_a[i].cyc), 64'(exp_a[i].cyc));
    end
    n = (got_b.size() < exp_b.size()) ? got_b.size() : exp_b.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_adr_b"}, 64'(got_b[i].adr), 64'(exp_b[i].adr));
      check({tag, "_dat_b"}, got_b[i].dat, exp_b[i].dat);
      check({tag, "_lat_b"}, 64'(got_b[i].cyc), 64'(exp_b[i].cyc));
    end
    got_a.delete(); exp_a.delete(); got_b.delete(); exp_b.delete();
  endtask

  task automatic end_checks(input string tag);
    int ea, eb;
    ea = (m_words[0] < 255) ? m_words[0] : 255;
    eb = (m_words[1] < 3) ? m_words[1] : 3;
    check({tag, "_period_a"}, 64'(dec_period_a), 64'(mrun));
    check({tag, "_period_b"}, 64'(dec_period_b), 64'(mrun));
    check({tag, "_ovf_a"}, 64'(ovf_a), 64'(m_ovf[0]));
    check({tag, "_ovf_b"}, 64'(ovf_b), 64'(m_ovf[1]));
    check({tag, "_bitcnt_a"}, 64'(bitcnt_a), 64'(macc));
    check({tag, "_bitcnt_b"}, 64'(bitcnt_b), 64'(macc));
    check({tag, "_wradr_a"}, 64'(wr_adr_a), 64'(ea));
    check({tag, "_wradr_b"}, 64'(wr_adr_b), 64'(eb));
    compare_writes(tag);
  endtask

  // pat: 0 random, 1 alternating 1,0 on data bits, 2 all ones.
  // stop_at >= 0 ends the strobe train early: with abort_p if abort_stop, else silently.
  task automatic payload(input bit fec, input bit crc, input int len, input int stop_at,
                         input bit abort_stop, input bit st_with_ab, input int pat,
                         input string tag);
    int   tot, nstr;
    logic b;
    bit   ab, en, ed;
    tot = len + (crc ? 16 : 0);
    @(posedge clk_6M); #1;
    fec32encode = fec; crcencode = crc; pylenbit = LEN_W'(len);
    dec_st_p = 1'b1; abort_p = st_with_ab;
    if (tot != 0 || mrun) begin
      mrun = (tot != 0); mtot = tot; mfec = fec;
      model_clear();
    end
    @(posedge clk_6M); #1;
    dec_st_p = 1'b0; abort_p = 1'b0;
    nstr = fec ? ((tot + 9) / 10) * 15 : tot;
    for (int s = 0; s < nstr; s++) begin
      if (stop_at >= 0 && s == stop_at && !abort_stop) break;
      repeat ($urandom_range(0, 2)) begin @(posedge clk_6M); #1; end
      ab = (stop_at >= 0 && s == stop_at);
      en = mrun && (!mfec || (mpos % 15) < 10);
      case (pat)
        1:       b = (macc % 2 == 0);
        2:       b = 1'b1;
        default: b = 1'($urandom_range(0, 1));
      endcase
      ed = en && !ab && (macc == mtot - 1);
      py_datvalid_p = 1'b1; rxbit = b; abort_p = ab;
      @(negedge clk_6M);
      check({tag, "_daten_a"}, 64'(daten_a), 64'(en));
      check({tag, "_daten_b"}, 64'(daten_b), 64'(en));
      check({tag, "_endp_a"}, 64'(dec_endp_a), 64'(ed));
      check({tag, "_endp_b"}, 64'(dec_endp_b), 64'(ed));
      check({tag, "_inrun_a"}, 64'(dec_period_a), 64'(mrun));
      if (en && !ab) model_bit(b, cyc);
      if (mrun) mpos++;
      if (ab) mrun = 1'b0;
      @(posedge clk_6M); #1;
      py_datvalid_p = 1'b0; abort_p = 1'b0;
      if (ab) begin
        check({tag, "_abort_idle"}, 64'(dec_period_a), 64'(0));
        break;
      end
    end
    repeat (3) @(posedge clk_6M);
    #1;
    end_checks(tag);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_wrp_a"}, 64'(wr_p_a), 64'(0));
    check({tag, "_wrp_b"}, 64'(wr_p_b), 64'(0));
    check({tag, "_period_a"}, 64'(dec_period_a), 64'(0));
    check({tag, "_daten_a"}, 64'(daten_a), 64'(0));
    check({tag, "_bitcnt_a"}, 64'(bitcnt_a), 64'(0));
    check({tag, "_wradr_a"}, 64'(wr_adr_a), 64'(0));
    check({tag, "_wrdat_a"}, 64'(wr_dat_a), 64'(0));
    check({tag, "_ovf_b"}, 64'(ovf_b), 64'(0));
  endtask

  initial begin
    rstz = 1'b0; py_datvalid_p = 1'b0; dec_st_p = 1'b0; abort_p = 1'b0;
    fec32encode = 1'b0; crcencode = 1'b0; rxbit = 1'b0; pylenbit = '0;
    mrun = 1'b0; mfec = 1'b0; mtot = 0;
    model_clear();
    repeat (3) @(posedge clk_6M);
    @(negedge clk_6M);
    reset_checks("rst");
    rstz = 1'b1;
    @(posedge clk_6M); #1;
    check("rel_wrp_a", 64'(wr_p_a), 64'(0));

    payload(1'b0, 1'b0, 64, -1, 1'b0, 1'b0, 1, "alt64");
    check("alt64_word", first_a, 64'h5555_5555);
    payload(1'b0, 1'b1, 40, -1, 1'b0, 1'b0, 0, "crc40");
    payload(1'b1, 1'b0, 20, -1, 1'b0, 1'b0, 2, "fec20");
    check("fec20_word", first_a, 64'h000F_FFFF);
    check("fec20_bitcnt", 64'(bitcnt_a), 64'd20);
    payload(1'b0, 1'b0, 48, -1, 1'b0, 1'b0, 0, "len48");
    check("len48_ovf_b", 64'(ovf_b), 64'd1);
    payload(1'b0, 1'b0, 64, 16, 1'b1, 1'b0, 0, "abort17");
    payload(1'b0, 1'b0, 0, -1, 1'b0, 1'b0, 0, "zero");
    payload(1'b0, 1'b0, 64, -1, 1'b0, 1'b0, 0, "after_abort");
    payload(1'b1, 1'b1, 100, 40, 1'b0, 1'b0, 0, "cut");
    payload(1'b0, 1'b0, 70, -1, 1'b0, 1'b1, 0, "st_ab");

    payload(1'b0, 1'b0, 64, 20, 1'b0, 1'b0, 0, "pre_rst");
    rstz = 1'b0;
    @(negedge clk_6M);
    reset_checks("midrst");
    rstz = 1'b1;
    mrun = 1'b0;
    model_clear();
    repeat (3) @(posedge clk_6M);
    #1;
    end_checks("post_rst");

    for (int i = 0; i < 8; i++) begin
      payload(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(1, 120)), -1, 1'b0, 1'b0, 0, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/py_rxword_pack.md
PY_RXWORD_PACK -- requirements
Module: py_rxword_pack

Interface
REQ-001 Parameter WORD_W, default 32, SRAM write word width in bits; legal values 8, 16, 32 or 64.
REQ-002 Parameter ADR_W, default 8, SRAM word-address width.
REQ-003 Parameter LEN_W, default 13, payload bit-length width.
REQ-004 One clock; reset is asynchronous and active-low: clk_6M  input  1  system clock; rstz  input  1  async active-low reset.
REQ-005 py_datvalid_p  input  1  one-cycle bit strobe at the current symbol rate.
REQ-006 dec_st_p  input  1  one-cycle start of payload decode.
REQ-007 abort_p  input  1  one-cycle cancel, e.g. on sync loss or slot end.
REQ-008 fec32encode  input  1  payload is FEC 2/3 coded: 15-bit blocks, first 10 are data.
REQ-009 crcencode  input  1  payload carries a 16-bit CRC, which is packed like data.
REQ-010 pylenbit  input  LEN_W  payload data length in bits, excluding CRC.
REQ-011 rxbit  input  1  decoded bit, sampled only on py_datvalid_p.
REQ-012 daten  output  1  current strobe position carries a data bit; low on FEC parity positions.
REQ-013 dec_period  output  1  decode in progress.
REQ-014 bitcnt  output  LEN_W  data bits accepted so far.
REQ-015 dec_endp  output  1  one-cycle pulse coincident with the last data bit.
REQ-016 wr_p  output  1  one-cycle SRAM write strobe.
REQ-017 wr_adr  output  ADR_W  word address for wr_p.
REQ-018 wr_dat  output  WORD_W  packed word, first-received bit at bit 0.
REQ-019 ovf  output  1  sticky flag: the payload exceeded 2^ADR_W words.

Function
REQ-020 total = pylenbit + 16 when crcencode is 1, else pylenbit; computed at LEN_W+1 bits with no truncation.
REQ-021 States: IDLE and RUN.
- IDLE -> RUN on dec_st_p with total != 0.
- dec_st_p with total == 0 is ignored.
REQ-022 RUN -> IDLE on the last data bit (bitcnt == total-1 with daten & py_datvalid_p), or on abort_p.
REQ-023 dec_st_p in RUN restarts the decode: bitcnt, block counter, shift register and wr_adr clear; ovf clears.
REQ-024 FEC block counter (0..14) advances on each py_datvalid_p in RUN and wraps 14 -> 0.
- daten = 1 for counts 0..9 and 0 for counts 10..14.
- When fec32encode = 0, daten = dec_period.
REQ-025 On daten & py_datvalid_p, shift register <= {rxbit, shreg[WORD_W-1:1]} and bitcnt increments.
REQ-026 On a full word (bitcnt[log2(WORD_W)-1:0] == WORD_W-1 at a data bit):
- wr_p pulses the following cycle, with wr_dat = shreg and the current wr_adr;
- wr_adr increments after the write.
REQ-027 On a final partial word of k bits (0 < k < WORD_W):
- one cycle after dec_endp, wr_p pulses with wr_dat = shreg >> (WORD_W-k), upper bits zero;
- no extra strobes are consumed.
REQ-028 If the last bit completes a full word, exactly one write is issued; no empty trailing word is written.
REQ-029 When a write would exceed address 2^ADR_W-1, set ovf, suppress that and all later writes until the next dec_st_p; wr_adr does not wrap.
REQ-030 abort_p wins over a simultaneous data bit: no write, no dec_endp, return to IDLE; shreg contents are discarded.
REQ-031 abort_p and dec_st_p in the same cycle: dec_st_p wins, giving a clean restart.
REQ-032 Total latency from the completing data bit to wr_p is 1 clk_6M cycle.

Reset
REQ-033 On rstz low, all outputs and state asynchronously clear to 0/IDLE; wr_p is never asserted during reset or in the first cycle after release.
REQ-034 Reset mid-payload discards the partial word; no write is issued.

Structure
REQ-035 A shared package holds FEC_BLK = 15, FEC_DAT = 10, CRC_BITS = 16 and the state enum.
REQ-036 One sub-module, py_fec32_gate, holds the block counter and daten generation.

Verification
REQ-037 WORD_W=32, fec32encode=0, crcencode=0, pylenbit=64, data alternating 1,0 -> two wr_p, adr 0,1, wr_dat = 0x55555555 each, dec_endp on the 64th strobe.
REQ-038 WORD_W=32, pylenbit=40, crcencode=1 (total 56) -> writes at adr 0 and 1; the second word has 24 valid bits and wr_dat[31:24] = 0.
REQ-039 fec32encode=1, pylenbit=20, all-ones -> 30 strobes consumed, bitcnt = 20, daten low on strobes 11-15 and 26-30, one write 0x000FFFFF.
REQ-040 ADR_W=2, WORD_W=8, pylenbit=48 -> four writes (adr 0..3), ovf = 1 on the fifth word, no fifth wr_p.
REQ-041 abort_p on the 17th strobe of a 64-bit payload -> no wr_p, dec_period = 0 the next cycle; a following dec_st_p restarts at adr 0.
REQ-042 dec_st_p with pylenbit = 0 and crcencode = 0 -> dec_period stays 0 and no outputs change.
